// File: rtl/vga_text_render.sv
// 640x480@60 raster stage that renders a one-line text buffer through a 3x5 glyph ROM.
// Optional blinking cursor over slot cur_pos is built when VGA_CURSOR_EN is defined.
module vga_text_render #(
    parameter int          CLK_DIV = 2,
    parameter int          SCALE   = 8,
    parameter int          NCHAR   = 8,
    parameter int          X0      = 64,
    parameter int          Y0      = 200,
    parameter logic [2:0]  FG      = 3'b111,
    parameter logic [2:0]  BG      = 3'b001,
    parameter int          H_VIS   = 640,
    parameter int          H_FP    = 16,
    parameter int          H_SY    = 96,
    parameter int          H_BP    = 48,
    parameter int          V_VIS   = 480,
    parameter int          V_FP    = 10,
    parameter int          V_SY    = 2,
    parameter int          V_BP    = 33,
    localparam int         AW      = $clog2(NCHAR)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_data,
    input  logic [AW-1:0] cur_pos,
    output logic [3:0]    ra,
    input  logic [15:0]   rd,
    output logic          hsync,
    output logic          vsync,
    output logic [2:0]    rgb,
    output logic          frame_start
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SY + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SY + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SS      = $clog2(SCALE);
    localparam int NSLOT   = 1 << AW;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
    localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SY);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SY);
    localparam logic [HW-1:0] X0_C     = HW'(X0);
    localparam logic [VW-1:0] Y0_C     = VW'(Y0);
    localparam logic [HW-1:0] TXT_W    = HW'(NCHAR * 4 * SCALE);
    localparam logic [VW-1:0] TXT_H    = VW'(5 * SCALE);

    logic [DW-1:0]    div;
    logic [HW-1:0]    hcnt;
    logic [VW-1:0]    vcnt;
    logic [3:0]       text [NSLOT];
    logic [NSLOT-1:0] valid;

    logic            tick;
    logic [HW-1:0]   dx;
    logic [VW-1:0]   dy;
    logic            in_text;
    logic [AW-1:0]   slot;
    logic [1:0]      col;
    logic [2:0]      row;
    logic [3:0]      bit_idx;
    logic            glyph_on;
    logic            pix_on;
    logic            video_on;
    logic            wr_ok;

    // Only a partially populated address space needs a range check on writes.
    if (NCHAR == NSLOT) begin : g_full
        assign wr_ok = 1'b1;
    end else begin : g_part
        assign wr_ok = ({1'b0, wr_addr} < (AW + 1)'(NCHAR));
    end

    assign tick = (div == DIV_LAST);

    always_comb begin
        dx       = hcnt - X0_C;
        dy       = vcnt - Y0_C;
        in_text  = (hcnt >= X0_C) && (dx < TXT_W) && (vcnt >= Y0_C) && (dy < TXT_H);
        slot     = dx[SS+2 +: AW];
        col      = dx[SS +: 2];
        row      = dy[SS +: 3];
        bit_idx  = 4'(row) * 4'd3 + {2'b00, col};
        ra       = in_text ? text[slot] : 4'd0;
        glyph_on = in_text && valid[slot] && (col != 2'd3) && rd[4'd15 - bit_idx];
        video_on = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
    end

`ifdef VGA_CURSOR_EN
    logic [5:0] frame_cnt;
    logic       cursor_hit;

    // Blink period is 32 frames on, 32 frames off; the cursor inverts glyph and background.
    assign cursor_hit = !frame_cnt[5] && in_text && (col != 2'd3) && (slot == cur_pos);
    assign pix_on     = glyph_on ^ cursor_hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (tick && hcnt == H_LAST && vcnt == V_LAST) begin
            frame_cnt <= frame_cnt + 6'd1;
        end
    end
`else
    logic unused_cur;
    assign unused_cur = ^cur_pos;
    assign pix_on     = glyph_on;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            div         <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            valid       <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            rgb         <= 3'd0;
            frame_start <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                text[i] <= 4'd0;
            end
        end else begin
            frame_start <= 1'b0;
            // Same-cycle render of the written slot still sees the old glyph.
            if (wr_en && wr_ok) begin
                text[wr_addr]  <= wr_data;
                valid[wr_addr] <= 1'b1;
            end
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                if (hcnt == H_LAST) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
                hsync       <= !((hcnt >= HS_BEG) && (hcnt < HS_END));
                vsync       <= !((vcnt >= VS_BEG) && (vcnt < VS_END));
                rgb         <= !video_on ? 3'd0 : (pix_on ? FG : BG);
                frame_start <= (hcnt == '0) && (vcnt == '0);
            end
        end
    end

endmodule
